// File: rtl/mode_button_ctrl.sv
// mode_button_ctrl: turns the two active-low board buttons into the shared 2-bit
// distortion mode. Synchronise, debounce, edge-detect, then step the mode with
// wrap-around, auto-repeat on hold and lock-out when both buttons are pressed.
module mode_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLD_CYCLES     = 25_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000,
   parameter logic [1:0]  RESET_MODE      = 2'b00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       key_up_n,
   input  logic       key_down_n,
   output logic [1:0] mode,
   output logic       mode_changed,
   output logic       up_db,
   output logic       down_db
);

   localparam int unsigned MAX_HR  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned MAX_ALL = (MAX_HR > DEBOUNCE_CYCLES) ? MAX_HR : DEBOUNCE_CYCLES;
   localparam int unsigned TW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

   localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2,
      S_LOCK   = 2'd3
   } state_t;

   logic [1:0]    up_sync_q, dn_sync_q;
   logic          up_s, dn_s;
   logic [TW-1:0] up_cnt_q, dn_cnt_q;
   logic          up_db_q, dn_db_q;
   logic          up_prev_q, dn_prev_q;
   logic          up_rise, dn_rise;
   logic [1:0]    vld_q;
   logic          armed_q;
   state_t        state_q;
   logic          dir_q;
   logic [TW-1:0] tmr_q;
   logic [1:0]    mode_q;
   logic          mode_changed_q;
   logic          act_held, other_held;
   logic [1:0]    step_mode;

   // Two-flop synchronisers; idle level of the pins is 1 (released)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         up_sync_q <= 2'b11;
         dn_sync_q <= 2'b11;
      end else begin
         up_sync_q <= {up_sync_q[0], key_up_n};
         dn_sync_q <= {dn_sync_q[0], key_down_n};
      end
   end

   assign up_s = ~up_sync_q[1];
   assign dn_s = ~dn_sync_q[1];

   // Per-key debounce: a level must differ for DEBOUNCE_CYCLES cycles before it is accepted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         up_cnt_q  <= '0;
         dn_cnt_q  <= '0;
         up_db_q   <= 1'b0;
         dn_db_q   <= 1'b0;
         up_prev_q <= 1'b0;
         dn_prev_q <= 1'b0;
      end else begin
         up_prev_q <= up_db_q;
         dn_prev_q <= dn_db_q;
         if (up_s == up_db_q) begin
            up_cnt_q <= '0;
         end else if (up_cnt_q == DB_LAST) begin
            up_db_q  <= ~up_db_q;
            up_cnt_q <= '0;
         end else begin
            up_cnt_q <= up_cnt_q + TW'(1);
         end
         if (dn_s == dn_db_q) begin
            dn_cnt_q <= '0;
         end else if (dn_cnt_q == DB_LAST) begin
            dn_db_q  <= ~dn_db_q;
            dn_cnt_q <= '0;
         end else begin
            dn_cnt_q <= dn_cnt_q + TW'(1);
         end
      end
   end

   // Arm stepping only once both keys are seen released after reset, so a key held
   // through reset cannot produce a step until it is released and pressed again
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_q   <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         vld_q <= {vld_q[0], 1'b1};
         if (vld_q[1] && !up_s && !dn_s && !up_db_q && !dn_db_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign up_rise    = up_db_q & ~up_prev_q;
   assign dn_rise    = dn_db_q & ~dn_prev_q;
   assign act_held   = dir_q ? up_db_q : dn_db_q;
   assign other_held = dir_q ? dn_db_q : up_db_q;
   assign step_mode  = dir_q ? (mode_q + 2'd1) : (mode_q - 2'd1);

   // Step FSM with registered mode and one-cycle change pulse
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         dir_q          <= 1'b1;
         tmr_q          <= '0;
         mode_q         <= RESET_MODE;
         mode_changed_q <= 1'b0;
      end else begin
         mode_changed_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (up_rise || dn_rise) begin
                  if (!armed_q || (up_rise && dn_db_q) || (dn_rise && up_db_q)) begin
                     state_q <= S_LOCK;
                  end else if (up_rise) begin
                     mode_q         <= mode_q + 2'd1;
                     mode_changed_q <= 1'b1;
                     dir_q          <= 1'b1;
                     tmr_q          <= '0;
                     state_q        <= S_HOLD;
                  end else begin
                     mode_q         <= mode_q - 2'd1;
                     mode_changed_q <= 1'b1;
                     dir_q          <= 1'b0;
                     tmr_q          <= '0;
                     state_q        <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!act_held) begin
                  state_q <= S_IDLE;
               end else if (other_held) begin
                  state_q <= S_LOCK;
               end else if (tmr_q == HOLD_LAST) begin
                  mode_q         <= step_mode;
                  mode_changed_q <= 1'b1;
                  tmr_q          <= '0;
                  state_q        <= S_REPEAT;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            S_REPEAT: begin
               if (!act_held) begin
                  state_q <= S_IDLE;
               end else if (other_held) begin
                  state_q <= S_LOCK;
               end else if (tmr_q == REP_LAST) begin
                  mode_q         <= step_mode;
                  mode_changed_q <= 1'b1;
                  tmr_q          <= '0;
               end else begin
                  tmr_q <= tmr_q + TW'(1);
               end
            end
            default: begin
               if (!up_db_q && !dn_db_q) begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign mode         = mode_q;
   assign mode_changed = mode_changed_q;
   assign up_db        = up_db_q;
   assign down_db      = dn_db_q;

endmodule

// File: tb/tb_mode_button_ctrl.sv
// Bench for mode_button_ctrl with short debounce/hold/repeat periods.
// Expected mode steps (value and cycle) are queued when a key is driven and
// matched against each mode_changed pulse by a monitor.
module tb_mode_button_ctrl;

   localparam int unsigned DB   = 4;
   localparam int unsigned HOLD = 20;
   localparam int unsigned REP  = 8;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic       key_up_n   = 1'b1;
   logic       key_down_n = 1'b1;
   logic [1:0] mode;
   logic       mode_changed;
   logic       up_db;
   logic       down_db;

   int unsigned cyc      = 0;
   int          checks   = 0;
   int          failures = 0;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  mode;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] model_mode = 2'b00;

   mode_button_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES    (HOLD),
      .REPEAT_CYCLES  (REP),
      .RESET_MODE     (2'b00)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_up_n    (key_up_n),
      .key_down_n  (key_down_n),
      .mode        (mode),
      .mode_changed(mode_changed),
      .up_db       (up_db),
      .down_db     (down_db)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Queue the next mode step, expected to appear with mode_changed at cycle 'at'
   task automatic push_step(input bit up, input int unsigned at);
      exp_t e;
      model_mode = up ? model_mode + 2'd1 : model_mode - 2'd1;
      e.cyc  = at;
      e.mode = model_mode;
      exp_q.push_back(e);
   endtask

   // Every mode_changed pulse must match the oldest queued step
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mode_changed === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse cyc=%0d mode=%b", cyc, mode);
            end else begin
               e = exp_q.pop_front();
               if (mode !== e.mode || cyc != e.cyc) begin
                  failures++;
                  $display("FAIL step_pulse got mode=%b cyc=%0d exp mode=%b cyc=%0d",
                           mode, cyc, e.mode, e.cyc);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", mode); end
      checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", mode_changed); end
      checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL reset_up_db got=%b exp=0", up_db); end
      checks++; if (down_db !== 1'b0) begin failures++; $display("FAIL reset_down_db got=%b exp=0", down_db); end
      reset_n = 1'b1;
      tick(12);
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL idle_mode got=%b exp=00", mode); end
      checks++; if (up_db !== 1'b0 || down_db !== 1'b0) begin
         failures++; $display("FAIL idle_db got=%b%b exp=00", up_db, down_db);
      end
   endtask

   task automatic test_glitch();
      bit seen = 1'b0;
      key_up_n = 1'b0;
      tick(3);
      key_up_n = 1'b1;
      repeat (12) begin
         tick(1);
         if (up_db !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_db got=1 exp=0"); end
      checks++; if (mode !== model_mode) begin failures++; $display("FAIL glitch_mode got=%b exp=%b", mode, model_mode); end
   endtask

   task automatic test_wrap_up();
      int unsigned t0;
      t0 = cyc;
      push_step(1'b0, t0 + 7);
      key_down_n = 1'b0;
      tick(10);
      key_down_n = 1'b1;
      tick(20);
      checks++; if (mode !== 2'b11) begin failures++; $display("FAIL wrap_down_mode got=%b exp=11", mode); end
      t0 = cyc;
      push_step(1'b1, t0 + 7);
      key_up_n = 1'b0;
      tick(5);
      checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL up_db_early got=%b exp=0", up_db); end
      tick(1);
      checks++; if (up_db !== 1'b1) begin failures++; $display("FAIL up_db_latency got=%b exp=1", up_db); end
      tick(4);
      key_up_n = 1'b1;
      tick(20);
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL wrap_up_mode got=%b exp=00", mode); end
      checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL up_db_release got=%b exp=0", up_db); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing_pulse got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_hold_repeat();
      int unsigned t0;
      t0 = cyc;
      push_step(1'b0, t0 + 7);
      push_step(1'b0, t0 + 7 + HOLD);
      push_step(1'b0, t0 + 7 + HOLD + REP);
      push_step(1'b0, t0 + 7 + HOLD + 2 * REP);
      key_down_n = 1'b0;
      tick(30);
      checks++; if (mode !== 2'b10) begin failures++; $display("FAIL hold_mid_mode got=%b exp=10", mode); end
      tick(10);
      key_down_n = 1'b1;
      tick(25);
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL repeat_mode got=%b exp=00", mode); end
      checks++; if (down_db !== 1'b0) begin failures++; $display("FAIL down_db_release got=%b exp=0", down_db); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL repeat_missing_pulse got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_both_lock();
      int unsigned t0;
      key_up_n   = 1'b0;
      key_down_n = 1'b0;
      tick(6);
      checks++; if (up_db !== 1'b1 || down_db !== 1'b1) begin
         failures++; $display("FAIL both_db got=%b%b exp=11", up_db, down_db);
      end
      tick(24);
      key_up_n   = 1'b1;
      key_down_n = 1'b1;
      tick(20);
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL both_mode got=%b exp=00", mode); end
      t0 = cyc;
      push_step(1'b1, t0 + 7);
      key_up_n = 1'b0;
      tick(10);
      key_up_n = 1'b1;
      tick(20);
      checks++; if (mode !== 2'b01) begin failures++; $display("FAIL after_lock_mode got=%b exp=01", mode); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lock_missing_pulse got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_hold();
      int unsigned t0;
      t0 = cyc;
      push_step(1'b1, t0 + 7);
      key_up_n = 1'b0;
      tick(12);
      checks++; if (mode !== 2'b10) begin failures++; $display("FAIL pre_reset_mode got=%b exp=10", mode); end
      reset_n = 1'b0;
      tick(1);
      model_mode = 2'b00;
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL mid_reset_mode got=%b exp=00", mode); end
      checks++; if (mode_changed !== 1'b0) begin failures++; $display("FAIL mid_reset_pulse got=%b exp=0", mode_changed); end
      checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL mid_reset_up_db got=%b exp=0", up_db); end
      tick(2);
      reset_n = 1'b1;
      tick(20);
      checks++; if (up_db !== 1'b1) begin failures++; $display("FAIL held_up_db got=%b exp=1", up_db); end
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL held_mode got=%b exp=00", mode); end
      key_up_n = 1'b1;
      tick(20);
      checks++; if (up_db !== 1'b0) begin failures++; $display("FAIL held_release_db got=%b exp=0", up_db); end
      t0 = cyc;
      push_step(1'b1, t0 + 7);
      key_up_n = 1'b0;
      tick(10);
      key_up_n = 1'b1;
      tick(20);
      checks++; if (mode !== 2'b01) begin failures++; $display("FAIL repress_mode got=%b exp=01", mode); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL repress_missing_pulse got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_glitch();
      test_wrap_up();
      test_hold_repeat();
      test_both_lock();
      test_reset_mid_hold();
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
